spin_sequencer: RTL and testbench
=================================

# spin_sequencer

Game-level controller between the host command path (SPI command fields, already in the pixel-clock domain) and the reel renderer. Accepts one spin/credit command at a time, latches final reel sprites, fires a frame-aligned start pulse, supervises the reel-done handshake with a frame timeout, then rolls the displayed credit total up to its target and reports completion to the host. Replaces the constant reel/start tie-offs in the top level.

## Interface
Parameters:
- NUM_SPRITES, 6: valid sprite indices are 0..NUM_SPRITES-1 (max 8).
- TIMEOUT_FRAMES, 600: frames allowed between start pulse and reel done.
- WIN_HOLD_FRAMES, 60: frames the win amount is shown before roll-up.
- CREDIT_STEP, 4: max credits added to the display per frame during roll-up.

Ports:
- clk  in  1  pixel clock (PLL output)
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  VGA vsync, active-low pulse
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_spin  in  1  1 = spin command, 0 = credit-only update
- cmd_reel1/2/3  in  4 each  final sprite index per reel
- cmd_win_credits  in  12  win amount
- cmd_is_win  in  1  win amount is valid
- cmd_total_credits  in  12  new credit total
- cmd_is_total  in  1  total is valid
- final1/2/3_sprite  out  3 each  to renderer
- start_spin  out  1  one-cycle pulse to renderer
- reel_done  in  1  renderer reports reels stopped (level or pulse)
- win_credits_disp  out  12  win amount for display
- win_show  out  1  win amount overlay enable
- credits_disp  out  12  displayed credit total
- result_valid  out  1  one-cycle pulse: command finished
- cmd_reject  out  1  one-cycle pulse: invalid index or busy
- fault  out  1  sticky reel timeout
- state_led  out  3  encoded state

## Operation
- States (state_led code): IDLE 0, ARM 1, SPIN 2, WAIT_DONE 3, SHOW_WIN 4, ROLL 5, FINISH 6.
- frame_tick: vsync 1->0 edge, vsync registered once.
- IDLE: on cmd_valid & cmd_ready: if cmd_spin and any reel index >= NUM_SPRITES -> cmd_reject, stay IDLE. Else latch all cmd fields, clear fault; cmd_spin -> ARM, else -> ROLL (if cmd_is_total) or FINISH.
- cmd_valid outside IDLE: cmd_reject pulse, command dropped, state unaffected.
- ARM: wait frame_tick -> SPIN. SPIN: start_spin=1 for exactly one cycle, frame counter cleared -> WAIT_DONE.
- WAIT_DONE: reel_done -> SHOW_WIN if latched is_win, else ROLL/FINISH as above. Counter increments on frame_tick; reaching TIMEOUT_FRAMES -> fault=1, -> FINISH. reel_done and timeout same cycle: reel_done wins.
- SHOW_WIN: win_show=1; hold WIN_HOLD_FRAMES frame ticks -> ROLL/FINISH. win_show clears on leaving.
- ROLL: per frame_tick, if credits_disp < target: add min(CREDIT_STEP, target-credits_disp); if credits_disp > target: load target at once. Equal -> FINISH. No overflow possible (target is 12-bit).
- FINISH: result_valid one cycle -> IDLE.
- final*_sprite: low 3 bits of latched indices, stable from accept until next accepted spin.

## Timing
- Reset values: state IDLE, cmd_ready 1, start_spin 0, all sprites 0, win_credits_disp 0, win_show 0, credits_disp 0, result_valid 0, cmd_reject 0, fault 0, state_led 0.
- Accept to ARM: 1 cycle. start_spin asserted the cycle after the state register enters SPIN, i.e. 2 cycles after the frame_tick cycle; never two pulses per command.
- frame_tick latency: 2 clk after vsync falls at input.
- Reset mid-operation: immediate return to reset values; no start_spin or result_valid emitted.

## Structure
- slot_pkg: seq_state_t enum, sprite_idx_t (3-bit), credit_t (12-bit), state_led encodings.
- Sub-module vsync_edge_detect: synchronizing register plus falling-edge tick.

## Test plan
- Spin 2/0/1, no win, total 100 from 100: one start_spin after next frame_tick, sprites 2/0/1, reel_done -> result_valid, credits_disp 100.
- Win 20, total 120 from 100, step 4: win_show for 60 frames, then credits_disp 104,108,…,120 over 5 frames, result_valid.
- Credit-only total 50 from 120: credits_disp = 50 on first frame_tick in ROLL, no start_spin.
- Reel index 7 with NUM_SPRITES 6: cmd_reject pulse, state stays IDLE, sprites unchanged.
- reel_done never asserted: fault=1 after 600 frames, result_valid, next accepted command clears fault.
- cmd_valid during WAIT_DONE and reset_n low during ROLL: reject pulse with no state change; reset returns all outputs to reset values.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and state encodings for the slot game sequencer.
// Sprite indices and credit amounts are sized here so the renderer and sequencer agree.
package slot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_SPIN      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_SHOW_WIN  = 3'd4,
      ST_ROLL      = 3'd5,
      ST_FINISH    = 3'd6
   } seq_state_t;

   typedef logic [2:0]  sprite_idx_t;
   typedef logic [11:0] credit_t;

   localparam logic [2:0] LED_IDLE      = 3'd0;
   localparam logic [2:0] LED_ARM       = 3'd1;
   localparam logic [2:0] LED_SPIN      = 3'd2;
   localparam logic [2:0] LED_WAIT_DONE = 3'd3;
   localparam logic [2:0] LED_SHOW_WIN  = 3'd4;
   localparam logic [2:0] LED_ROLL      = 3'd5;
   localparam logic [2:0] LED_FINISH    = 3'd6;

   localparam int FRAME_CNT_W = 16;

   function automatic logic [2:0] state_led_code(input seq_state_t s);
      case (s)
         ST_IDLE:      return LED_IDLE;
         ST_ARM:       return LED_ARM;
         ST_SPIN:      return LED_SPIN;
         ST_WAIT_DONE: return LED_WAIT_DONE;
         ST_SHOW_WIN:  return LED_SHOW_WIN;
         ST_ROLL:      return LED_ROLL;
         ST_FINISH:    return LED_FINISH;
         default:      return LED_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/spin_sequencer_vsync_edge_detect.sv
// Registers the active-low vsync and emits a one-cycle frame tick on its falling edge.
// The tick is itself registered, so it appears two clocks after vsync falls at the pin.
module vsync_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic vsync,
   output logic frame_tick
);

   logic vsync_r;
   logic vsync_d_r;
   logic tick_r;

   // vsync sampling pipeline and registered falling-edge detect; idle level of vsync is high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_r   <= 1'b1;
         vsync_d_r <= 1'b1;
         tick_r    <= 1'b0;
      end else begin
         vsync_r   <= vsync;
         vsync_d_r <= vsync_r;
         tick_r    <= vsync_d_r & ~vsync_r;
      end
   end

   assign frame_tick = tick_r;

endmodule

// File: rtl/spin_sequencer.sv
// Game-level sequencer: accepts spin/credit commands, fires a frame-aligned reel start,
// supervises reel completion with a frame timeout, then rolls the credit display to target.
module spin_sequencer
   import slot_pkg::*;
#(
   parameter int NUM_SPRITES     = 6,
   parameter int TIMEOUT_FRAMES  = 600,
   parameter int WIN_HOLD_FRAMES = 60,
   parameter int CREDIT_STEP     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_spin,
   input  logic [3:0]  cmd_reel1,
   input  logic [3:0]  cmd_reel2,
   input  logic [3:0]  cmd_reel3,
   input  logic [11:0] cmd_win_credits,
   input  logic        cmd_is_win,
   input  logic [11:0] cmd_total_credits,
   input  logic        cmd_is_total,
   output logic [2:0]  final1_sprite,
   output logic [2:0]  final2_sprite,
   output logic [2:0]  final3_sprite,
   output logic        start_spin,
   input  logic        reel_done,
   output logic [11:0] win_credits_disp,
   output logic        win_show,
   output logic [11:0] credits_disp,
   output logic        result_valid,
   output logic        cmd_reject,
   output logic        fault,
   output logic [2:0]  state_led
);

   seq_state_t             state_r, next_s;
   logic                   frame_tick_s;
   logic [FRAME_CNT_W-1:0] frame_cnt_r;
   logic                   accept_s, reject_s, bad_idx_s, timeout_s;
   seq_state_t             post_s;
   credit_t                target_r, credits_disp_r, win_credits_r;
   credit_t                diff_s, step_s, roll_next_s;
   logic                   is_win_r, is_total_r;
   sprite_idx_t            sprite1_r, sprite2_r, sprite3_r;
   logic                   cmd_ready_r, start_spin_r, win_show_r, result_valid_r;
   logic                   cmd_reject_r, fault_r;
   logic [2:0]             state_led_r;

   vsync_edge_detect u_vsync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .vsync      (vsync),
      .frame_tick (frame_tick_s)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= next_s;
   end

   // next-state decode, command accept/reject and timeout detection
   always_comb begin
      next_s    = state_r;
      accept_s  = 1'b0;
      timeout_s = 1'b0;
      bad_idx_s = cmd_spin & ((cmd_reel1 >= 4'(NUM_SPRITES)) |
                              (cmd_reel2 >= 4'(NUM_SPRITES)) |
                              (cmd_reel3 >= 4'(NUM_SPRITES)));
      reject_s  = cmd_valid & ((state_r != ST_IDLE) | bad_idx_s);
      post_s    = is_total_r ? ST_ROLL : ST_FINISH;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && !bad_idx_s) begin
               accept_s = 1'b1;
               if (cmd_spin)          next_s = ST_ARM;
               else if (cmd_is_total) next_s = ST_ROLL;
               else                   next_s = ST_FINISH;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (frame_tick_s) next_s = ST_SPIN;
            else              next_s = ST_ARM;
         end
         ST_SPIN: next_s = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            // reel_done takes priority over a timeout landing on the same cycle
            if (reel_done) begin
               next_s = is_win_r ? ST_SHOW_WIN : post_s;
            end else if (frame_tick_s &&
                         frame_cnt_r == FRAME_CNT_W'(TIMEOUT_FRAMES - 1)) begin
               timeout_s = 1'b1;
               next_s    = ST_FINISH;
            end else begin
               next_s = ST_WAIT_DONE;
            end
         end
         ST_SHOW_WIN: begin
            if (frame_tick_s && frame_cnt_r == FRAME_CNT_W'(WIN_HOLD_FRAMES - 1)) next_s = post_s;
            else next_s = ST_SHOW_WIN;
         end
         ST_ROLL: begin
            if (credits_disp_r == target_r) next_s = ST_FINISH;
            else                            next_s = ST_ROLL;
         end
         ST_FINISH: next_s = ST_IDLE;
         default:   next_s = ST_IDLE;
      endcase
   end

   // roll-up step: climb by at most CREDIT_STEP, drop to a lower target at once
   always_comb begin
      diff_s = target_r - credits_disp_r;
      if (diff_s > credit_t'(CREDIT_STEP)) step_s = credit_t'(CREDIT_STEP);
      else                                 step_s = diff_s;
      if (credits_disp_r < target_r) roll_next_s = credits_disp_r + step_s;
      else                           roll_next_s = target_r;
   end

   // frame counter, restarted on every state change
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               frame_cnt_r <= '0;
      else if (next_s != state_r) frame_cnt_r <= '0;
      else if (frame_tick_s)      frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
   end

   // command latches, credit display and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_r       <= '0;
         is_win_r       <= 1'b0;
         is_total_r     <= 1'b0;
         win_credits_r  <= '0;
         credits_disp_r <= '0;
         sprite1_r      <= '0;
         sprite2_r      <= '0;
         sprite3_r      <= '0;
         cmd_ready_r    <= 1'b1;
         start_spin_r   <= 1'b0;
         win_show_r     <= 1'b0;
         result_valid_r <= 1'b0;
         cmd_reject_r   <= 1'b0;
         fault_r        <= 1'b0;
         state_led_r    <= LED_IDLE;
      end else begin
         if (accept_s) begin
            target_r      <= cmd_total_credits;
            is_win_r      <= cmd_is_win;
            is_total_r    <= cmd_is_total;
            win_credits_r <= cmd_win_credits;
            // sprites persist across credit-only updates
            if (cmd_spin) begin
               sprite1_r <= cmd_reel1[2:0];
               sprite2_r <= cmd_reel2[2:0];
               sprite3_r <= cmd_reel3[2:0];
            end
         end
         if (state_r == ST_ROLL && frame_tick_s) credits_disp_r <= roll_next_s;
         if (accept_s)       fault_r <= 1'b0;
         else if (timeout_s) fault_r <= 1'b1;
         cmd_ready_r    <= (next_s == ST_IDLE);
         start_spin_r   <= (state_r == ST_SPIN);
         win_show_r     <= (next_s == ST_SHOW_WIN);
         result_valid_r <= (next_s == ST_FINISH);
         cmd_reject_r   <= reject_s;
         state_led_r    <= state_led_code(next_s);
      end
   end

   assign cmd_ready        = cmd_ready_r;
   assign final1_sprite    = sprite1_r;
   assign final2_sprite    = sprite2_r;
   assign final3_sprite    = sprite3_r;
   assign start_spin       = start_spin_r;
   assign win_credits_disp = win_credits_r;
   assign win_show         = win_show_r;
   assign credits_disp     = credits_disp_r;
   assign result_valid     = result_valid_r;
   assign cmd_reject       = cmd_reject_r;
   assign fault            = fault_r;
   assign state_led        = state_led_r;

endmodule

// File: tb/tb_spin_sequencer.sv
// Directed-plus-random bench for spin_sequencer; expected values come from a
// frame-level model of the game rules (credit arithmetic, event counts, latencies).
module tb_spin_sequencer;

   localparam int NS   = 6;
   localparam int TO   = 600;
   localparam int HOLD = 60;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        reset_n, vsync, cmd_valid, cmd_spin, cmd_is_win, cmd_is_total, reel_done;
   logic [3:0]  cmd_reel1, cmd_reel2, cmd_reel3;
   logic [11:0] cmd_win_credits, cmd_total_credits;
   logic        cmd_ready, start_spin, win_show, result_valid, cmd_reject, fault;
   logic [2:0]  final1_sprite, final2_sprite, final3_sprite, state_led;
   logic [11:0] win_credits_disp, credits_disp;

   spin_sequencer #(.NUM_SPRITES(NS), .TIMEOUT_FRAMES(TO), .WIN_HOLD_FRAMES(HOLD),
                    .CREDIT_STEP(STEP)) dut (
      .clk(clk), .reset_n(reset_n), .vsync(vsync),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_spin(cmd_spin),
      .cmd_reel1(cmd_reel1), .cmd_reel2(cmd_reel2), .cmd_reel3(cmd_reel3),
      .cmd_win_credits(cmd_win_credits), .cmd_is_win(cmd_is_win),
      .cmd_total_credits(cmd_total_credits), .cmd_is_total(cmd_is_total),
      .final1_sprite(final1_sprite), .final2_sprite(final2_sprite),
      .final3_sprite(final3_sprite), .start_spin(start_spin), .reel_done(reel_done),
      .win_credits_disp(win_credits_disp), .win_show(win_show),
      .credits_disp(credits_disp), .result_valid(result_valid),
      .cmd_reject(cmd_reject), .fault(fault), .state_led(state_led)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;
   int ss_count = 0;
   int rv_count = 0;
   int ss_cyc = 0;
   int fall_cyc = 0;
   int cq[$];
   logic [11:0] prev_cred = 12'd0;

   // model state
   int m_cred = 0;
   int m_s1 = 0, m_s2 = 0, m_s3 = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (start_spin === 1'b1) begin
         ss_count <= ss_count + 1;
         ss_cyc   <= cyc;
      end
      if (result_valid === 1'b1) rv_count <= rv_count + 1;
      prev_cred <= credits_disp;
      if (credits_disp !== prev_cred) cq.push_back(int'(credits_disp));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one video frame: vsync low for 2 clocks, 16 clocks per frame
   task automatic frame();
      @(negedge clk);
      vsync = 1'b0;
      fall_cyc = cyc;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (13) @(negedge clk);
   endtask

   task automatic send(input logic sp, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic iw, input int w,
                       input logic it, input int t);
      @(negedge clk);
      cmd_spin = sp; cmd_reel1 = a; cmd_reel2 = b; cmd_reel3 = c;
      cmd_is_win = iw; cmd_win_credits = 12'(w);
      cmd_is_total = it; cmd_total_credits = 12'(t);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic chk_sprites(input string tag);
      chk({tag, "_s1"}, 32'(final1_sprite), m_s1);
      chk({tag, "_s2"}, 32'(final2_sprite), m_s2);
      chk({tag, "_s3"}, 32'(final3_sprite), m_s3);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_led"}, 32'(state_led), 0);
      chk({tag, "_ready"}, 32'(cmd_ready), 1);
      chk({tag, "_start"}, 32'(start_spin), 0);
      chk({tag, "_cred"}, 32'(credits_disp), 0);
      chk({tag, "_win"}, 32'(win_credits_disp), 0);
      chk({tag, "_winshow"}, 32'(win_show), 0);
      chk({tag, "_rv"}, 32'(result_valid), 0);
      chk({tag, "_rej"}, 32'(cmd_reject), 0);
      chk({tag, "_fault"}, 32'(fault), 0);
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      chk_sprites(tag);
   endtask

   // expected display sequence derived from the roll-up rule
   task automatic check_roll(input string tag, input int from, input int to);
      int c;
      int exp_q[$];
      c = from;
      if (c > to) exp_q.push_back(to);
      else while (c < to) begin
         c += (to - c > STEP) ? STEP : (to - c);
         exp_q.push_back(c);
      end
      chk({tag, "_rolllen"}, cq.size(), exp_q.size());
      foreach (exp_q[i]) if (i < cq.size()) chk({tag, "_rollval"}, cq[i], exp_q[i]);
   endtask

   task automatic wait_result(input int rv0, input int max_frames);
      for (int f = 0; f < max_frames && rv_count == rv0; f++) frame();
   endtask

   task automatic run_credit(input string tag, input int t);
      int rv0, ss0;
      rv0 = rv_count; ss0 = ss_count;
      cq.delete();
      // invalid reel fields are ignored on a credit-only update
      send(1'b0, 4'd15, 4'($urandom_range(0, 15)), 4'd9, 1'b0, 0, 1'b1, t);
      chk({tag, "_fault_clr"}, 32'(fault), 0);
      chk({tag, "_led_roll"}, 32'(state_led), 5);
      wait_result(rv0, 1100);
      cycles(2);
      check_roll(tag, m_cred, t);
      m_cred = t;
      chk({tag, "_result"}, rv_count - rv0, 1);
      chk({tag, "_cred"}, 32'(credits_disp), m_cred);
      chk({tag, "_nostart"}, ss_count - ss0, 0);
      chk({tag, "_idle"}, 32'(state_led), 0);
      chk_sprites(tag);
   endtask

   task automatic run_spin(input string tag, input int a, input int b, input int c,
                           input logic iw, input int w, input logic it, input int t,
                           input int done_frames, input logic busy_probe);
      int rv0, ss0;
      rv0 = rv_count; ss0 = ss_count;
      send(1'b1, 4'(a), 4'(b), 4'(c), iw, w, it, t);
      m_s1 = a; m_s2 = b; m_s3 = c;
      chk({tag, "_led_arm"}, 32'(state_led), 1);
      chk({tag, "_ready_lo"}, 32'(cmd_ready), 0);
      chk_sprites(tag);
      frame();
      // tick 2 clocks after the fall, pulse 2 cycles after the tick cycle
      chk({tag, "_start_lat"}, ss_cyc - fall_cyc, 4);
      chk({tag, "_start_once"}, ss_count - ss0, 1);
      chk({tag, "_led_wait"}, 32'(state_led), 3);
      if (busy_probe) begin
         send(1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 0, 1'b1, 0);
         chk({tag, "_busy_rej"}, 32'(cmd_reject), 1);
         chk({tag, "_busy_led"}, 32'(state_led), 3);
         cycles(1);
         chk({tag, "_busy_rej_end"}, 32'(cmd_reject), 0);
         chk_sprites({tag, "_busy"});
      end
      repeat (done_frames) frame();
      cq.delete();
      @(negedge clk) reel_done = 1'b1;
      @(negedge clk) reel_done = 1'b0;
      if (iw) begin
         chk({tag, "_winshow"}, 32'(win_show), 1);
         chk({tag, "_winamt"}, 32'(win_credits_disp), w);
         repeat (HOLD - 1) frame();
         chk({tag, "_win_hold"}, 32'(win_show), 1);
         frame();
         chk({tag, "_win_end"}, 32'(win_show), 0);
      end
      if (it) begin
         wait_result(rv0, 1100);
         cycles(2);
         check_roll(tag, m_cred, t);
         m_cred = t;
      end else begin
         cycles(3);
      end
      chk({tag, "_result"}, rv_count - rv0, 1);
      chk({tag, "_cred"}, 32'(credits_disp), m_cred);
      chk({tag, "_one_start"}, ss_count - ss0, 1);
      chk({tag, "_fault"}, 32'(fault), 0);
      chk({tag, "_idle"}, 32'(state_led), 0);
   endtask

   initial begin
      int rv0, ss0, t;
      reset_n = 1'b0; vsync = 1'b1; cmd_valid = 1'b0; cmd_spin = 1'b0;
      cmd_reel1 = 4'd0; cmd_reel2 = 4'd0; cmd_reel3 = 4'd0;
      cmd_win_credits = 12'd0; cmd_is_win = 1'b0;
      cmd_total_credits = 12'd0; cmd_is_total = 1'b0; reel_done = 1'b0;
      cycles(3);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      cycles(3);

      run_credit("init100", 100);
      run_spin("spin201", 2, 0, 1, 1'b0, 0, 1'b1, 100, 2, 1'b1);
      run_spin("win20", int'($urandom_range(0, NS - 1)), int'($urandom_range(0, NS - 1)),
               int'($urandom_range(0, NS - 1)), 1'b1, 20, 1'b1, 120, 1, 1'b0);
      run_credit("down50", 50);

      // out-of-range reel index on a spin
      send(1'b1, 4'($urandom_range(0, NS - 1)), 4'd7, 4'($urandom_range(0, 15)),
           1'b0, 0, 1'b1, 0);
      chk("badidx_rej", 32'(cmd_reject), 1);
      chk("badidx_led", 32'(state_led), 0);
      chk("badidx_ready", 32'(cmd_ready), 1);
      chk_sprites("badidx");
      cycles(1);
      chk("badidx_rej_end", 32'(cmd_reject), 0);

      // reel_done never arrives
      rv0 = rv_count; ss0 = ss_count;
      send(1'b1, 4'd5, 4'd3, 4'd0, 1'b1, 40, 1'b1, 900);
      m_s1 = 5; m_s2 = 3; m_s3 = 0;
      repeat (TO) frame();
      chk("to_nofault_yet", 32'(fault), 0);
      chk("to_noresult_yet", rv_count - rv0, 0);
      frame();
      chk("to_fault", 32'(fault), 1);
      chk("to_result", rv_count - rv0, 1);
      chk("to_cred", 32'(credits_disp), m_cred);
      chk("to_winshow", 32'(win_show), 0);
      chk("to_start", ss_count - ss0, 1);
      run_credit("to_clear", m_cred);

      for (int i = 0; i < 3; i++) begin
         t = m_cred + int'($urandom_range(0, 40)) - 20;
         if (t < 0) t = 0;
         run_spin("rnd", int'($urandom_range(0, NS - 1)), int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, NS - 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), t,
                  int'($urandom_range(0, 3)), 1'b0);
      end

      // reset asserted in the middle of a long roll-up
      rv0 = rv_count; ss0 = ss_count;
      send(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 1'b1, m_cred + 400);
      frame(); frame();
      chk("rst_rolling", 32'(state_led), 5);
      @(negedge clk) reset_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      cycles(4);
      chk("midreset_norv", rv_count - rv0, 0);
      chk("midreset_nostart", ss_count - ss0, 0);
      reset_n = 1'b1;
      m_cred = 0;
      cycles(2);
      run_spin("post_rst", 4, 4, 4, 1'b0, 0, 1'b1, 8, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
